// File: rtl/omega_update_ctrl.sv
// omega_update_ctrl: takes the frequency word from the SPI slave when a frame
// ends, waits for an NCO phase-accumulator wrap (with a timeout fallback), then
// writes it to the NCO omega input.
// Optional feature macro: OMEGA_RAMP_EN. When it is defined, omega slews
// toward the target in RAMP_STEP increments, one step every RAMP_DIV clocks,
// instead of jumping to it.
//
// state       | meaning
// S_IDLE      | no update pending
// S_CAPTURE   | latch spi_data as the new target and restart the wrap timer
// S_WAIT_WRAP | wait for nco_wrap, or force the update when the timer expires
// S_APPLY     | omega was just written (no ramp), or the ramp is about to start
// S_RAMP      | step omega toward the target (OMEGA_RAMP_EN only)
module omega_update_ctrl #(
  parameter int          OMEGA_W  = 40,
  parameter logic [15:0] WRAP_TMO = 16'hFFFF
`ifdef OMEGA_RAMP_EN
  ,
  parameter logic [OMEGA_W-1:0] RAMP_STEP = {{(OMEGA_W-9){1'b0}}, 9'h100},
  parameter logic [15:0]        RAMP_DIV  = 16'd1000
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               spi_ssel,
  input  logic [OMEGA_W-1:0] spi_data,
  input  logic               nco_wrap,
  input  logic               clr_status,
  output logic [63:0]        omega,
  output logic               omega_load,
  output logic               busy,
  output logic               overrun,
  output logic               timeout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAPTURE,
    S_WAIT_WRAP,
    S_APPLY
`ifdef OMEGA_RAMP_EN
    ,
    S_RAMP
`endif
  } state_t;

  state_t             state;
  logic               ssel_meta, ssel_sync, ssel_prev;
  logic               frame_done;
  logic [OMEGA_W-1:0] target;
  logic [OMEGA_W-1:0] omega_r;
  logic [15:0]        tmo_cnt;
`ifdef OMEGA_RAMP_EN
  logic [15:0]        div_cnt;
  logic               cap_pend;
  logic [OMEGA_W-1:0] diff;
  logic               up;
`endif

  assign omega      = {{(64-OMEGA_W){1'b0}}, omega_r};
  assign frame_done = ssel_sync & ~ssel_prev;

  // Synchronize slave select and keep one delayed copy for the rising-edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ssel_meta <= 1'b1;
      ssel_sync <= 1'b1;
      ssel_prev <= 1'b1;
    end else begin
      ssel_meta <= spi_ssel;
      ssel_sync <= ssel_meta;
      ssel_prev <= ssel_sync;
    end
  end

`ifdef OMEGA_RAMP_EN
  // Distance to the target and the direction of the next ramp step
  always_comb begin
    up   = (target >= omega_r);
    diff = up ? (target - omega_r) : (omega_r - target);
  end
`endif

  // Update sequencer; omega is written on the transition into APPLY, so
  // omega_load is high during the APPLY cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      target     <= '0;
      omega_r    <= '0;
      tmo_cnt    <= '0;
      omega_load <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
      timeout    <= 1'b0;
`ifdef OMEGA_RAMP_EN
      div_cnt    <= '0;
      cap_pend   <= 1'b0;
`endif
    end else begin
      omega_load <= 1'b0;
      // set events later in this block override the clear
      if (clr_status) begin
        overrun <= 1'b0;
        timeout <= 1'b0;
      end
      case (state)
        S_IDLE: begin
          if (frame_done) begin
            state <= S_CAPTURE;
            busy  <= 1'b1;
          end
        end
        S_CAPTURE: begin
          target  <= spi_data;
          tmo_cnt <= '0;
          // another frame ending here: stay and recapture on the next cycle
          if (frame_done) overrun <= 1'b1;
          else            state   <= S_WAIT_WRAP;
        end
        S_WAIT_WRAP: begin
          if (frame_done) begin
            overrun <= 1'b1;
            state   <= S_CAPTURE;
          end else if (nco_wrap || (tmo_cnt == WRAP_TMO)) begin
            if (!nco_wrap) timeout <= 1'b1;
            state <= S_APPLY;
`ifndef OMEGA_RAMP_EN
            omega_r    <= target;
            omega_load <= 1'b1;
`endif
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
        end
        S_APPLY: begin
          if (frame_done) begin
            overrun <= 1'b1;
            state   <= S_CAPTURE;
          end else begin
`ifdef OMEGA_RAMP_EN
            state   <= S_RAMP;
            div_cnt <= '0;
`else
            state   <= S_IDLE;
            busy    <= 1'b0;
`endif
          end
        end
`ifdef OMEGA_RAMP_EN
        S_RAMP: begin
          // a new frame retargets one cycle later; no wrap wait while ramping
          cap_pend <= frame_done;
          if (frame_done) overrun <= 1'b1;
          if (cap_pend) begin
            target <= spi_data;
          end else if (div_cnt == RAMP_DIV - 16'd1) begin
            div_cnt    <= '0;
            omega_load <= 1'b1;
            if (diff <= RAMP_STEP) begin
              omega_r <= target;
              if (!frame_done) begin
                state <= S_IDLE;
                busy  <= 1'b0;
              end
            end else if (up) begin
              omega_r <= omega_r + RAMP_STEP;
            end else begin
              omega_r <= omega_r - RAMP_STEP;
            end
          end else begin
            div_cnt <= div_cnt + 16'd1;
          end
        end
`endif
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_omega_update_ctrl.sv
// Testbench for omega_update_ctrl. Randomized frames and wrap timing are
// checked against expectations derived from the update rules: load latency
// after frame end, the last frame winning, and sticky status behaviour.
module tb_omega_update_ctrl;
  localparam int          OW  = 40;
  localparam logic [15:0] TMO = 16'd16;
  localparam int          NH  = 256;
`ifdef OMEGA_RAMP_EN
  localparam logic [OW-1:0] RSTEP = 40'd4;
  localparam int            RDIV  = 2;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          spi_ssel = 1'b1;
  logic [OW-1:0] spi_data = '0;
  logic          nco_wrap = 1'b0;
  logic          clr_status = 1'b0;
  logic [63:0]   omega;
  logic          omega_load, busy, overrun, timeout;

  int checks = 0;
  int fails = 0;
  logic [63:0] mdl_omega = '0;

  logic        ld_h[NH];
  logic        busy_h[NH];
  logic        tmo_h[NH];
  logic        ovr_h[NH];
  logic [63:0] om_h[NH];

  omega_update_ctrl #(
    .OMEGA_W(OW),
    .WRAP_TMO(TMO)
`ifdef OMEGA_RAMP_EN
    ,
    .RAMP_STEP(RSTEP),
    .RAMP_DIV(16'(RDIV))
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n), .spi_ssel(spi_ssel), .spi_data(spi_data),
    .nco_wrap(nco_wrap), .clr_status(clr_status), .omega(omega),
    .omega_load(omega_load), .busy(busy), .overrun(overrun), .timeout(timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [OW-1:0] rand_word();
    return {8'($urandom()), 32'($urandom())};
  endfunction

  // Cycle 0 = the cycle ssel rises; frame_done is seen two cycles later.
  // History index c holds outputs sampled just after clock edge c.
  task automatic run_frame(input logic [OW-1:0] d1, input int r2, input logic [OW-1:0] d2,
                           input int wrap_c, input int clr_from, input int clr_to, input int ncyc);
    for (int i = 0; i < NH; i++) begin
      ld_h[i] = 1'b0; busy_h[i] = 1'b0; tmo_h[i] = 1'b0; ovr_h[i] = 1'b0; om_h[i] = '0;
    end
    spi_ssel = 1'b0;
    tick();
    tick();
    spi_data = d1;
    spi_ssel = 1'b1;
    for (int c = 1; c <= ncyc; c++) begin
      tick();
      ld_h[c] = omega_load; busy_h[c] = busy; tmo_h[c] = timeout;
      ovr_h[c] = overrun; om_h[c] = omega;
      nco_wrap   = (c == wrap_c);
      clr_status = (c >= clr_from) && (c <= clr_to);
      if (c == r2 - 1) spi_ssel = 1'b0;
      if (c == r2) begin
        spi_ssel = 1'b1;
        spi_data = d2;
      end
    end
    nco_wrap = 1'b0;
    clr_status = 1'b0;
  endtask

  function automatic int count_loads(input int n);
    int s = 0;
    for (int c = 1; c <= n; c++) if (ld_h[c]) s++;
    return s;
  endfunction

  function automatic int first_load(input int n);
    for (int c = 1; c <= n; c++) if (ld_h[c]) return c;
    return -1;
  endfunction

  // frame_done (cycle 2 after the ssel rise) + 3, plus the wrap wait capped at WRAP_TMO
  function automatic int exp_load(input int fd, input int k);
    return fd + 3 + ((k <= int'(TMO)) ? k : int'(TMO));
  endfunction

  task automatic test_reset();
    #3 rst_n = 1'b0;
    tick();
    tick();
    checks++; if (omega !== 64'd0) begin fails++; $display("FAIL reset_omega: got %h want 0", omega); end
    checks++; if (omega_load !== 1'b0) begin fails++; $display("FAIL reset_load: got %b want 0", omega_load); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (overrun !== 1'b0) begin fails++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    checks++; if (timeout !== 1'b0) begin fails++; $display("FAIL reset_timeout: got %b want 0", timeout); end
    rst_n = 1'b1;
    repeat (4) tick();
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
    mdl_omega = '0;
  endtask

  task automatic test_wrap();
    logic [OW-1:0] d;
    int k, ec;
    for (int i = 0; i < 6; i++) begin
      case (i)
        0:       begin d = 40'h12_3456_789A; k = 10; end
        1:       begin d = rand_word(); k = 0; end
        2:       begin d = rand_word(); k = int'(TMO); end
        3:       begin d = mdl_omega[OW-1:0]; k = int'($urandom_range(0, 16)); end
        default: begin d = rand_word(); k = int'($urandom_range(0, 16)); end
      endcase
      run_frame(d, -1, '0, 4 + k, -1, -1, 30);
      ec = exp_load(2, k);
      checks++; if (count_loads(30) != 1) begin fails++; $display("FAIL wrap_load_count[%0d]: got %0d want 1", i, count_loads(30)); end
      checks++; if (first_load(30) != ec) begin fails++; $display("FAIL wrap_latency[%0d]: got cycle %0d want %0d (k=%0d)", i, first_load(30), ec, k); end
      checks++; if (om_h[ec-1] !== mdl_omega) begin fails++; $display("FAIL wrap_old_omega[%0d]: got %h want %h", i, om_h[ec-1], mdl_omega); end
      mdl_omega = {24'd0, d};
      checks++; if (om_h[ec] !== mdl_omega) begin fails++; $display("FAIL wrap_omega[%0d]: got %h want %h", i, om_h[ec], mdl_omega); end
      checks++; if (busy_h[ec] !== 1'b1 || busy_h[ec+1] !== 1'b0) begin fails++; $display("FAIL wrap_busy_fall[%0d]: got %b%b want 10", i, busy_h[ec], busy_h[ec+1]); end
      checks++; if (tmo_h[30] !== 1'b0) begin fails++; $display("FAIL wrap_no_timeout[%0d]: got %b want 0 (k=%0d)", i, tmo_h[30], k); end
    end
  endtask

  task automatic test_timeout();
    logic [OW-1:0] d;
    int ec;
    d = rand_word();
    run_frame(d, -1, '0, -1, -1, -1, 30);
    ec = exp_load(2, 99);
    mdl_omega = {24'd0, d};
    checks++; if (first_load(30) != ec) begin fails++; $display("FAIL tmo_latency: got cycle %0d want %0d", first_load(30), ec); end
    checks++; if (count_loads(30) != 1) begin fails++; $display("FAIL tmo_load_count: got %0d want 1", count_loads(30)); end
    checks++; if (om_h[ec] !== mdl_omega) begin fails++; $display("FAIL tmo_omega: got %h want %h", om_h[ec], mdl_omega); end
    checks++; if (tmo_h[ec-1] !== 1'b0 || tmo_h[ec] !== 1'b1) begin fails++; $display("FAIL tmo_set: got %b%b want 01", tmo_h[ec-1], tmo_h[ec]); end
    // clear held across the expiry: clear takes effect first, then the set wins
    d = rand_word();
    run_frame(d, -1, '0, -1, 15, ec - 1, 30);
    mdl_omega = {24'd0, d};
    checks++; if (tmo_h[15] !== 1'b1 || tmo_h[16] !== 1'b0) begin fails++; $display("FAIL tmo_clear: got %b%b want 10", tmo_h[15], tmo_h[16]); end
    checks++; if (tmo_h[ec] !== 1'b1 || tmo_h[ec+1] !== 1'b1) begin fails++; $display("FAIL tmo_set_beats_clear: got %b%b want 11", tmo_h[ec], tmo_h[ec+1]); end
    checks++; if (om_h[ec] !== mdl_omega) begin fails++; $display("FAIL tmo_omega2: got %h want %h", om_h[ec], mdl_omega); end
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    checks++; if (timeout !== 1'b0) begin fails++; $display("FAIL tmo_clr_pulse: got %b want 0", timeout); end
  endtask

  task automatic test_overrun();
    logic [OW-1:0] d1, d2;
    int r2, k2, ec;
    for (int i = 0; i < 3; i++) begin
      if (i == 0) begin
        d1 = 40'h5; d2 = 40'hA; r2 = 5; k2 = 3;
      end else begin
        d1 = rand_word(); d2 = rand_word();
        r2 = int'($urandom_range(2, 8)); k2 = int'($urandom_range(0, 6));
      end
      run_frame(d1, r2, d2, r2 + 4 + k2, -1, -1, 30);
      ec = exp_load(r2 + 2, k2);
      mdl_omega = {24'd0, d2};
      checks++; if (count_loads(30) != 1) begin fails++; $display("FAIL ovr_load_count[%0d]: got %0d want 1", i, count_loads(30)); end
      checks++; if (first_load(30) != ec) begin fails++; $display("FAIL ovr_latency[%0d]: got cycle %0d want %0d", i, first_load(30), ec); end
      checks++; if (om_h[30] !== mdl_omega) begin fails++; $display("FAIL ovr_omega[%0d]: got %h want %h", i, om_h[30], mdl_omega); end
      checks++; if (ovr_h[r2+2] !== 1'b0 || ovr_h[r2+3] !== 1'b1) begin fails++; $display("FAIL ovr_set[%0d]: got %b%b want 01", i, ovr_h[r2+2], ovr_h[r2+3]); end
      clr_status = 1'b1;
      tick();
      clr_status = 1'b0;
      checks++; if (overrun !== 1'b0) begin fails++; $display("FAIL ovr_clear[%0d]: got %b want 0", i, overrun); end
    end
  endtask

`ifdef OMEGA_RAMP_EN
  task automatic test_ramp_up();
    logic [63:0] q[$];
    logic [63:0] cur;
    int j, last;
    cur = mdl_omega;
    while (cur != 64'd10) begin
      if (((cur > 10) ? cur - 10 : 10 - cur) <= 64'(RSTEP)) cur = 64'd10;
      else cur = (cur < 10) ? cur + 64'(RSTEP) : cur - 64'(RSTEP);
      q.push_back(cur);
    end
    run_frame(40'd10, -1, '0, 4, -1, -1, 40);
    checks++; if (count_loads(40) != q.size()) begin fails++; $display("FAIL ramp_tick_count: got %0d want %0d", count_loads(40), q.size()); end
    j = 0; last = -1;
    for (int c = 1; c <= 40; c++) begin
      if (ld_h[c]) begin
        if (j < q.size()) begin
          checks++; if (om_h[c] !== q[j]) begin fails++; $display("FAIL ramp_value[%0d]: got %0d want %0d", j, om_h[c], q[j]); end
        end
        if (last >= 0) begin
          checks++; if (c - last != RDIV) begin fails++; $display("FAIL ramp_spacing[%0d]: got %0d want %0d", j, c - last, RDIV); end
        end
        last = c; j++;
      end
    end
    if (last < 0) last = 39;
    checks++; if (busy_h[last+1] !== 1'b0) begin fails++; $display("FAIL ramp_idle: got busy %b want 0", busy_h[last+1]); end
    mdl_omega = 64'd10;
  endtask

  task automatic test_ramp_reverse();
    logic [63:0] prev, lo;
    int bad;
    run_frame(40'd100, -1, '0, 4, -1, -1, 120);
    checks++; if (om_h[120] !== 64'd100) begin fails++; $display("FAIL rev_start: got %0d want 100", om_h[120]); end
    run_frame(40'd0, 30, 40'd200, 4, -1, -1, 200);
    prev = 64'd100; lo = 64'd100; bad = 0;
    for (int c = 1; c <= 200; c++) begin
      if (ld_h[c]) begin
        if (((om_h[c] > prev) ? om_h[c] - prev : prev - om_h[c]) > 64'(RSTEP)) bad++;
        if (om_h[c] < lo) lo = om_h[c];
        prev = om_h[c];
      end
    end
    checks++; if (bad != 0) begin fails++; $display("FAIL rev_step_size: got %0d oversized steps want 0", bad); end
    checks++; if (!(lo > 64'd0 && lo < 64'd100)) begin fails++; $display("FAIL rev_turnaround: got min %0d want between 1 and 99", lo); end
    checks++; if (om_h[200] !== 64'd200) begin fails++; $display("FAIL rev_final: got %0d want 200", om_h[200]); end
    checks++; if (busy_h[200] !== 1'b0 || ovr_h[200] !== 1'b1) begin fails++; $display("FAIL rev_status: got busy %b overrun %b want 0 1", busy_h[200], ovr_h[200]); end
    mdl_omega = 64'd200;
  endtask
`endif

  task automatic test_reset_mid();
    int loads, busy_seen;
    run_frame(rand_word(), 3, rand_word(), -1, -1, -1, 10);
    checks++; if (busy !== 1'b1 || overrun !== 1'b1) begin fails++; $display("FAIL mid_pre: got busy %b overrun %b want 1 1", busy, overrun); end
    spi_ssel = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++; if (omega !== 64'd0) begin fails++; $display("FAIL mid_omega: got %h want 0", omega); end
    checks++; if ({omega_load, busy, overrun, timeout} !== 4'b0000) begin fails++; $display("FAIL mid_outputs: got %b want 0000", {omega_load, busy, overrun, timeout}); end
    tick();
    tick();
    rst_n = 1'b1;
    loads = 0; busy_seen = 0;
    for (int c = 0; c < 25; c++) begin
      tick();
      if (omega_load) loads++;
      if (busy) busy_seen++;
    end
    checks++; if (loads != 0 || busy_seen != 0) begin fails++; $display("FAIL mid_discard: got %0d loads %0d busy cycles want 0 0", loads, busy_seen); end
    checks++; if (omega !== 64'd0) begin fails++; $display("FAIL mid_omega_after: got %h want 0", omega); end
    mdl_omega = '0;
  endtask

  initial begin
    test_reset();
`ifdef OMEGA_RAMP_EN
    test_ramp_up();
    test_ramp_reverse();
`else
    test_wrap();
    test_timeout();
    test_overrun();
`endif
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
